// File: rtl/udp_tx_packetizer.sv
// ----------------------------------------------------------------------------
// udp_tx_packetizer
//
// Store-and-forward UDP transmit source. One complete payload frame is
// buffered while its length is counted; once the frame's last byte arrives a
// full UDP header is offered on the stack's header channel, followed by the
// buffered payload on the matching AXI-stream.
//
// Optional feature (compile-time macro):
//   UDP_TX_PACKETIZER_DROP_BAD_EN - frames whose last byte carries
//                                   s_axis_tuser=1 are discarded (frame_drop
//                                   pulse, no header/payload) instead of being
//                                   forwarded with the bad marker.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_*                   raw payload byte stream in (tuser = bad frame)
//   cfg_dest_ip/_source_port/_dest_port
//                              addressing, latched with the input tlast
//   m_udp_hdr_valid/_ready     header channel handshake
//   m_udp_ip_*, m_udp_*        header fields (stable while hdr_valid)
//   m_udp_payload_axis_*       buffered payload byte stream out
//   busy                       header or payload in progress
//   frame_sent                 one-cycle pulse after the last payload handshake
//   frame_drop                 one-cycle pulse when a frame is discarded
// ----------------------------------------------------------------------------
module udp_tx_packetizer #(
  parameter int          DEPTH    = 2048,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_source_port,
  input  logic [15:0] cfg_dest_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        busy,
  output logic        frame_sent,
  output logic        frame_drop
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {FILL, DROP, HDR, PAYLOAD} state_t;

  state_t        state_q;
  logic [AW-1:0] wr_cnt_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW-1:0] last_idx_q;   // index of the final payload byte (len-1)
  logic          bad_q;

  logic          hdr_valid_q;
  logic [31:0]   dest_ip_q;
  logic [15:0]   src_port_q;
  logic [15:0]   dst_port_q;
  logic [15:0]   length_q;

  logic          tvalid_q;
  logic [7:0]    tdata_q;
  logic          tlast_q;
  logic          tuser_q;
  logic          sent_q;
  logic          drop_q;

  logic [7:0]    mem [DEPTH];

  logic in_acc;
  logic wr_en;
  logic hdr_hs;
  logic pay_hs;

  assign s_axis_tready = (state_q == FILL) || (state_q == DROP);
  assign in_acc        = s_axis_tvalid && s_axis_tready;
  assign wr_en         = in_acc && (state_q == FILL);
  assign hdr_hs        = hdr_valid_q && m_udp_hdr_ready;
  assign pay_hs        = tvalid_q && m_udp_payload_axis_tready;

  // Read address for the registered RAM read. It only moves on a consumed
  // byte, so the RAM output register holds the presented byte while the sink
  // stalls and already carries the next byte the cycle after a handshake;
  // this is what keeps the stream bubble-free across tready toggles.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (state_q == HDR && hdr_hs) begin
      rd_ptr_d = '0;
    end else if (state_q == PAYLOAD && pay_hs) begin
      rd_ptr_d = tlast_q ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt_q] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q <= '0;
    end else begin
      tdata_q <= mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      last_idx_q  <= '0;
      bad_q       <= 1'b0;
      hdr_valid_q <= 1'b0;
      dest_ip_q   <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      length_q    <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      sent_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      sent_q   <= 1'b0;
      drop_q   <= 1'b0;
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        FILL: begin
          if (in_acc) begin
            if (s_axis_tlast) begin
`ifdef UDP_TX_PACKETIZER_DROP_BAD_EN
              if (s_axis_tuser) begin
                drop_q   <= 1'b1;
                wr_cnt_q <= '0;
              end else
`endif
              begin
                last_idx_q  <= wr_cnt_q;
                length_q    <= 16'(wr_cnt_q) + 16'd9;  // (wr_cnt+1) + 8
                dest_ip_q   <= cfg_dest_ip;
                src_port_q  <= cfg_source_port;
                dst_port_q  <= cfg_dest_port;
                bad_q       <= s_axis_tuser;
                hdr_valid_q <= 1'b1;
                state_q     <= HDR;
              end
            end else if (wr_cnt_q == LAST_ADDR) begin
              // Buffer full and the frame keeps going: discard the rest.
              drop_q   <= 1'b1;
              wr_cnt_q <= '0;
              state_q  <= DROP;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        DROP: begin
          if (in_acc && s_axis_tlast) begin
            state_q <= FILL;
          end
        end
        HDR: begin
          if (hdr_hs) begin
            hdr_valid_q <= 1'b0;
            tvalid_q    <= 1'b1;
            tlast_q     <= (last_idx_q == '0);
            tuser_q     <= bad_q && (last_idx_q == '0);
            state_q     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (pay_hs) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tuser_q  <= 1'b0;
              sent_q   <= 1'b1;
              wr_cnt_q <= '0;
              state_q  <= FILL;
            end else begin
              tlast_q <= (rd_ptr_d == last_idx_q);
              tuser_q <= bad_q && (rd_ptr_d == last_idx_q);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign m_udp_hdr_valid           = hdr_valid_q;
  assign m_udp_ip_dscp             = 6'd0;
  assign m_udp_ip_ecn              = 2'd0;
  assign m_udp_ip_ttl              = TTL;
  assign m_udp_ip_source_ip        = LOCAL_IP;
  assign m_udp_ip_dest_ip          = dest_ip_q;
  assign m_udp_source_port         = src_port_q;
  assign m_udp_dest_port           = dst_port_q;
  assign m_udp_length              = length_q;
  assign m_udp_checksum            = 16'd0;
  assign m_udp_payload_axis_tdata  = tdata_q;
  assign m_udp_payload_axis_tvalid = tvalid_q;
  assign m_udp_payload_axis_tlast  = tlast_q;
  assign m_udp_payload_axis_tuser  = tuser_q;
  assign busy                      = (state_q == HDR) || (state_q == PAYLOAD);
  assign frame_sent                = sent_q;
  assign frame_drop                = drop_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// ----------------------------------------------------------------------------
// tb_udp_tx_packetizer
//
// Scoreboard bench for udp_tx_packetizer (DEPTH=16). Stimulus pushes the
// expected header and payload bytes into queues; an independent monitor pops
// and compares on every header / payload handshake and also checks latency,
// hold-while-stalled and pulse timing.
// ----------------------------------------------------------------------------
module tb_udp_tx_packetizer;

  localparam int DEPTH = 16;
`ifdef UDP_TX_PACKETIZER_DROP_BAD_EN
  localparam bit DROP_BAD = 1'b1;
`else
  localparam bit DROP_BAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [31:0] cfg_dest_ip = '0;
  logic [15:0] cfg_source_port = '0;
  logic [15:0] cfg_dest_port = '0;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready = 1'b1;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip;
  logic [31:0] m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port;
  logic [15:0] m_udp_dest_port;
  logic [15:0] m_udp_length;
  logic [15:0] m_udp_checksum;
  logic [7:0]  m_udp_payload_axis_tdata;
  logic        m_udp_payload_axis_tvalid;
  logic        m_udp_payload_axis_tready = 1'b1;
  logic        m_udp_payload_axis_tlast;
  logic        m_udp_payload_axis_tuser;
  logic        busy;
  logic        frame_sent;
  logic        frame_drop;

  udp_tx_packetizer #(.DEPTH(DEPTH)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .s_axis_tdata              (s_axis_tdata),
    .s_axis_tvalid             (s_axis_tvalid),
    .s_axis_tready             (s_axis_tready),
    .s_axis_tlast              (s_axis_tlast),
    .s_axis_tuser              (s_axis_tuser),
    .cfg_dest_ip               (cfg_dest_ip),
    .cfg_source_port           (cfg_source_port),
    .cfg_dest_port             (cfg_dest_port),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_ip_dscp             (m_udp_ip_dscp),
    .m_udp_ip_ecn              (m_udp_ip_ecn),
    .m_udp_ip_ttl              (m_udp_ip_ttl),
    .m_udp_ip_source_ip        (m_udp_ip_source_ip),
    .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
    .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
    .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
    .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
    .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
    .busy                      (busy),
    .frame_sent                (frame_sent),
    .frame_drop                (frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] len;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
  } hdr_t;

  hdr_t        hq[$];
  logic [9:0]  pq[$];          // {tuser, tlast, tdata}
  logic [7:0]  stim[$];

  int vectors     = 0;
  int miscompares = 0;
  int exp_sent    = 0;
  int exp_drop    = 0;
  int sent_seen   = 0;
  int drop_seen   = 0;
  bit bp_mode     = 1'b0;

  function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Sink: header/payload ready generation.
  initial begin
    int stall;
    stall = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && m_udp_hdr_valid && stall < 10) begin
        m_udp_hdr_ready = 1'b0;
        stall++;
      end else begin
        m_udp_hdr_ready = 1'b1;
        if (!m_udp_hdr_valid) stall = 0;
      end
      m_udp_payload_axis_tready = bp_mode ? ~m_udp_payload_axis_tready : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          sent_pend, hdr_hs_prev, pay_adv_prev, hdr_hold, pay_hold;
    logic [127:0] hdr_snap;
    logic [10:0]  pay_snap;
    hdr_t         eh;
    logic [9:0]   ep;
    sent_pend = 0; hdr_hs_prev = 0; pay_adv_prev = 0; hdr_hold = 0; pay_hold = 0;
    hdr_snap = '0; pay_snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sent_pend = 0; hdr_hs_prev = 0; pay_adv_prev = 0; hdr_hold = 0; pay_hold = 0;
        continue;
      end
      if (sent_pend || frame_sent) check("frame_sent_pulse", frame_sent, sent_pend);
      if (sent_pend) check("in_ready_after_last", s_axis_tready, 1'b1);
      if (busy) check("in_ready_while_busy", s_axis_tready, 1'b0);
      if (hdr_hs_prev) check("payload_latency", m_udp_payload_axis_tvalid, 1'b1);
      if (pay_adv_prev) check("no_bubble", m_udp_payload_axis_tvalid, 1'b1);
      if (hdr_hold)
        check("hdr_hold", {m_udp_hdr_valid, m_udp_length, m_udp_ip_dest_ip,
                           m_udp_source_port, m_udp_dest_port}, hdr_snap);
      if (pay_hold)
        check("payload_hold", {m_udp_payload_axis_tvalid, m_udp_payload_axis_tuser,
                               m_udp_payload_axis_tlast, m_udp_payload_axis_tdata}, pay_snap);
      if (frame_drop) drop_seen++;
      if (frame_sent) sent_seen++;

      sent_pend = 0; hdr_hs_prev = 0; pay_adv_prev = 0; hdr_hold = 0; pay_hold = 0;
      if (m_udp_hdr_valid) begin
        if (m_udp_hdr_ready) begin
          if (hq.size() == 0) begin
            check("hdr_unexpected", 1'b1, 1'b0);
          end else begin
            eh = hq.pop_front();
            check("hdr_fields", {m_udp_length, m_udp_ip_dest_ip, m_udp_source_port,
                                 m_udp_dest_port}, eh);
            check("hdr_consts", {m_udp_ip_ttl, m_udp_ip_source_ip, m_udp_ip_dscp,
                                 m_udp_ip_ecn, m_udp_checksum},
                  {8'd64, 32'hC0A8_0180, 6'd0, 2'd0, 16'd0});
          end
          hdr_hs_prev = 1;
        end else begin
          hdr_hold = 1;
          hdr_snap = {m_udp_hdr_valid, m_udp_length, m_udp_ip_dest_ip,
                      m_udp_source_port, m_udp_dest_port};
        end
      end
      if (m_udp_payload_axis_tvalid) begin
        if (m_udp_payload_axis_tready) begin
          if (pq.size() == 0) begin
            check("payload_unexpected", 1'b1, 1'b0);
          end else begin
            ep = pq.pop_front();
            check("payload", {m_udp_payload_axis_tuser, m_udp_payload_axis_tlast,
                              m_udp_payload_axis_tdata}, ep);
            if (ep[8]) sent_pend = 1;
            else pay_adv_prev = 1;
          end
        end else begin
          pay_hold = 1;
          pay_snap = {m_udp_payload_axis_tvalid, m_udp_payload_axis_tuser,
                      m_udp_payload_axis_tlast, m_udp_payload_axis_tdata};
        end
      end
    end
  end

  task automatic fill(input int n, input logic [7:0] base, input logic [7:0] step);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(base + 8'(i) * step);
  endtask

  // Drive the bytes in stim as one frame and record what should come out.
  task automatic send(input logic [31:0] dip, input logic [15:0] sp,
                      input logic [15:0] dp, input bit bad);
    int   n;
    hdr_t h;
    n = stim.size();
    if (n > DEPTH || (bad && DROP_BAD)) begin
      exp_drop++;
    end else begin
      h.len = 16'(n + 8); h.dip = dip; h.sp = sp; h.dp = dp;
      hq.push_back(h);
      for (int i = 0; i < n; i++)
        pq.push_back({bad && (i == n - 1), (i == n - 1), stim[i]});
      exp_sent++;
    end
    cfg_dest_ip = dip; cfg_source_port = sp; cfg_dest_port = dp;
    for (int i = 0; i < n; i++) begin
      int guard;
      s_axis_tdata  = stim[i];
      s_axis_tlast  = (i == n - 1);
      s_axis_tuser  = bad && (i == n - 1);
      s_axis_tvalid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!s_axis_tready) begin
        guard++;
        if (guard > 2000) begin
          $display("FAIL input_timeout: got tready=0 expected tready=1");
          $fatal(1, "input stalled");
        end
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    // Scramble config to confirm it was latched with tlast.
    cfg_dest_ip = 32'hDEAD_BEEF; cfg_source_port = 16'hFFFF; cfg_dest_port = 16'hAAAA;
  endtask

  task automatic wait_idle();
    int  cyc;
    cyc = 0;
    while ((hq.size() != 0 || pq.size() != 0 || busy) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check("idle_timeout", (cyc < 3000), 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_in_ready", s_axis_tready, 1'b1);
    check("rst_outputs", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast,
                          m_udp_payload_axis_tuser, busy, frame_sent, frame_drop}, 7'd0);
    check("rst_fields", {m_udp_length, m_udp_dest_port, m_udp_ip_dest_ip,
                         m_udp_payload_axis_tdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    stim.delete();
    stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33); stim.push_back(8'h44);
    send(32'h0A00_0001, 16'd5000, 16'd1234, 1'b0);
    wait_idle();

    // Backpressure
    bp_mode = 1'b1;
    fill(7, 8'hA0, 8'h03);
    send(32'h0A00_0002, 16'd4000, 16'd80, 1'b0);
    wait_idle();
    bp_mode = 1'b0;

    // Overflow then a 3-byte frame
    fill(20, 8'h01, 8'h01);
    send(32'h0A00_0003, 16'd1, 16'd2, 1'b0);
    fill(3, 8'h55, 8'h11);
    send(32'h0A00_0004, 16'd3, 16'd4, 1'b0);
    wait_idle();

    // Boundaries: single byte and full buffer
    fill(1, 8'h7E, 8'h00);
    send(32'h0A00_0005, 16'd6, 16'd7, 1'b0);
    fill(16, 8'hF0, 8'h01);
    send(32'h0A00_0006, 16'd8, 16'd9, 1'b0);
    wait_idle();

    // Bad frame marker
    fill(5, 8'h30, 8'h02);
    send(32'h0A00_0007, 16'd10, 16'd11, 1'b1);
    wait_idle();

    // Reset mid-stream
    bp_mode = 1'b1;
    fill(12, 8'hC0, 8'h01);
    send(32'h0A00_0008, 16'd12, 16'd13, 1'b0);
    begin
      int cyc;
      cyc = 0;
      while (!m_udp_payload_axis_tvalid && cyc < 200) begin
        @(posedge clk);
        cyc++;
      end
      check("reset_test_reached_payload", (cyc < 200), 1'b1);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", s_axis_tready, 1'b1);
    check("midrst_outputs", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast,
                             m_udp_payload_axis_tuser, busy, m_udp_payload_axis_tdata,
                             m_udp_length}, '0);
    hq.delete();
    pq.delete();
    exp_sent--;
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(3, 8'h9A, 8'h01);
    send(32'h0A00_0009, 16'd14, 16'd15, 1'b0);
    wait_idle();

    check("frame_drop_count", drop_seen, exp_drop);
    check("frame_sent_count", sent_seen, exp_sent);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
